// File: rtl/exc_ctrl_pkg.sv
// Shared exception definitions: ExcCode values, sequencer states, request bundle.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package exc_ctrl_pkg;

    // MIPS ExcCode values as written into Cause[6:2]
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Source of the BadVAddr value for the selected exception
    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_ADDR = 2'd2
    } bv_sel_e;

    // Per-instruction request bundle, listed in priority order (highest first)
    typedef struct packed {
        logic intr;
        logic if_adel;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic adel;
        logic ades;
        logic eret;
    } exc_req_t;

    // EPC points at the branch when the faulting instruction sits in its delay slot
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic ds);
        return ds ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: picks the single highest-priority exception (or ERET) from the request bundle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
// Ports: req_i (request bundle) -> exc_valid_o, exc_code_o, is_eret_o, bv_sel_o.
module exc_prio_enc
    import exc_ctrl_pkg::*;
(
    input  exc_req_t   req_i,
    output logic       exc_valid_o,
    output logic [4:0] exc_code_o,
    output logic       is_eret_o,
    output bv_sel_e    bv_sel_o
);

    always_comb begin
        exc_valid_o = 1'b1;
        exc_code_o  = EXC_INT;
        is_eret_o   = 1'b0;
        bv_sel_o    = BV_NONE;
        if (req_i.intr) begin
            exc_code_o = EXC_INT;
        end else if (req_i.if_adel) begin
            exc_code_o = EXC_ADEL;
            bv_sel_o   = BV_PC;
        end else if (req_i.ri) begin
            exc_code_o = EXC_RI;
        end else if (req_i.ov) begin
            exc_code_o = EXC_OV;
        end else if (req_i.sys) begin
            exc_code_o = EXC_SYS;
        end else if (req_i.bp) begin
            exc_code_o = EXC_BP;
        end else if (req_i.adel) begin
            exc_code_o = EXC_ADEL;
            bv_sel_o   = BV_ADDR;
        end else if (req_i.ades) begin
            exc_code_o = EXC_ADES;
            bv_sel_o   = BV_ADDR;
        end else begin
            // ERET only surfaces when no exception is present
            exc_valid_o = 1'b0;
            is_eret_o   = req_i.eret;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: select, latch, commit, flush, redirect.
// Latency: detection to commit pulse 1 cycle; detection to redirect FLUSH_CYCLES+1 cycles.
// Backpressure: none; requests seen outside IDLE are dropped and re-execute after the handler.
// Ports: MEM-stage instruction info and exception flags, hw_int_i, CP0 Status/Cause/EPC in;
//        CP0 commit pulses with code/EPC/BD/BadVAddr, flush/stall and fetch redirect out.
// Option: define EXC_INT_SYNC_EN to pass hw_int_i through a 2-flop synchronizer.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_delayslot_i,
    input  logic        exc_if_adel_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_adel_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic [31:0] mem_addr_i,
    input  logic [5:0]  hw_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        exc_commit_o,
    output logic        eret_commit_o,
    output logic [4:0]  exc_code_o,
    output logic [31:0] exc_epc_o,
    output logic        exc_bd_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        exc_badvaddr_we_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [5:0] hw_int_s;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] int_meta_q;
    logic [5:0] int_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            int_meta_q <= '0;
            int_sync_q <= '0;
        end else begin
            int_meta_q <= hw_int_i;
            int_sync_q <= int_meta_q;
        end
    end

    assign hw_int_s = int_sync_q;
`else
    assign hw_int_s = hw_int_i;
`endif

    // Only IP/IM, IE and EXL take part in interrupt recognition
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

    logic int_pend;
    assign int_pend = (|({hw_int_s, cause_i[9:8]} & status_i[15:8])) & status_i[0] & ~status_i[1];

    exc_req_t   req;
    logic       pe_exc_valid;
    logic [4:0] pe_code;
    logic       pe_is_eret;
    bv_sel_e    pe_bv_sel;

    assign req = '{intr: int_pend, if_adel: exc_if_adel_i, ri: exc_ri_i, ov: exc_ov_i,
                   sys: exc_sys_i, bp: exc_bp_i, adel: exc_adel_i, ades: exc_ades_i,
                   eret: eret_i};

    exc_prio_enc u_prio (
        .req_i       (req),
        .exc_valid_o (pe_exc_valid),
        .exc_code_o  (pe_code),
        .is_eret_o   (pe_is_eret),
        .bv_sel_o    (pe_bv_sel)
    );

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        first_q, first_d;
    logic        is_eret_q, is_eret_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;
    logic        bd_q, bd_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bv_we_q, bv_we_d;
    logic [31:0] eret_pc_q, eret_pc_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        first_d    = 1'b0;
        is_eret_d  = is_eret_q;
        code_d     = code_q;
        epc_d      = epc_q;
        bd_d       = bd_q;
        badvaddr_d = badvaddr_q;
        bv_we_d    = bv_we_q;
        eret_pc_d  = eret_pc_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid_i && pe_exc_valid) begin
                    state_d   = ST_FLUSH;
                    cnt_d     = FLUSH_INIT;
                    first_d   = 1'b1;
                    is_eret_d = 1'b0;
                    code_d    = pe_code;
                    epc_d     = epc_of(mem_pc_i, mem_delayslot_i);
                    bd_d      = mem_delayslot_i;
                    bv_we_d   = (pe_bv_sel != BV_NONE);
                    if (pe_bv_sel == BV_PC) begin
                        badvaddr_d = mem_pc_i;
                    end else if (pe_bv_sel == BV_ADDR) begin
                        badvaddr_d = mem_addr_i;
                    end
                end else if (mem_valid_i && pe_is_eret) begin
                    // ERET leaves the exception record untouched; only the return target is kept
                    state_d   = ST_FLUSH;
                    cnt_d     = FLUSH_INIT;
                    first_d   = 1'b1;
                    is_eret_d = 1'b1;
                    eret_pc_d = epc_i;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_REDIRECT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            first_q    <= 1'b0;
            is_eret_q  <= 1'b0;
            code_q     <= '0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            badvaddr_q <= '0;
            bv_we_q    <= 1'b0;
            eret_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            first_q    <= first_d;
            is_eret_q  <= is_eret_d;
            code_q     <= code_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            badvaddr_q <= badvaddr_d;
            bv_we_q    <= bv_we_d;
            eret_pc_q  <= eret_pc_d;
        end
    end

    logic in_flush;
    logic in_redirect;
    assign in_flush    = (state_q == ST_FLUSH);
    assign in_redirect = (state_q == ST_REDIRECT);

    assign exc_commit_o      = in_flush & first_q & ~is_eret_q;
    assign eret_commit_o     = in_flush & first_q & is_eret_q;
    assign exc_code_o        = code_q;
    assign exc_epc_o         = epc_q;
    assign exc_bd_o          = bd_q;
    assign exc_badvaddr_o    = badvaddr_q;
    assign exc_badvaddr_we_o = bv_we_q & exc_commit_o;
    assign flush_o           = in_flush;
    assign stall_o           = in_flush;
    assign redirect_valid_o  = in_redirect;
    assign redirect_pc_o     = in_redirect ? (is_eret_q ? eret_pc_q : EXC_VECTOR) : 32'd0;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with default parameters (FLUSH_CYCLES=2, vector 0xBFC00380).
// Inputs change 1 ns after each rising edge; outputs are checked at that same point.
// Expected values are hand-computed constants.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_delayslot_i;
    logic        exc_if_adel_i;
    logic        exc_ri_i;
    logic        exc_ov_i;
    logic        exc_sys_i;
    logic        exc_bp_i;
    logic        exc_adel_i;
    logic        exc_ades_i;
    logic        eret_i;
    logic [31:0] mem_addr_i;
    logic [5:0]  hw_int_i;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    logic        exc_commit_o;
    logic        eret_commit_o;
    logic [4:0]  exc_code_o;
    logic [31:0] exc_epc_o;
    logic        exc_bd_o;
    logic [31:0] exc_badvaddr_o;
    logic        exc_badvaddr_we_o;
    logic        flush_o;
    logic        stall_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .mem_valid_i       (mem_valid_i),
        .mem_pc_i          (mem_pc_i),
        .mem_delayslot_i   (mem_delayslot_i),
        .exc_if_adel_i     (exc_if_adel_i),
        .exc_ri_i          (exc_ri_i),
        .exc_ov_i          (exc_ov_i),
        .exc_sys_i         (exc_sys_i),
        .exc_bp_i          (exc_bp_i),
        .exc_adel_i        (exc_adel_i),
        .exc_ades_i        (exc_ades_i),
        .eret_i            (eret_i),
        .mem_addr_i        (mem_addr_i),
        .hw_int_i          (hw_int_i),
        .status_i          (status_i),
        .cause_i           (cause_i),
        .epc_i             (epc_i),
        .exc_commit_o      (exc_commit_o),
        .eret_commit_o     (eret_commit_o),
        .exc_code_o        (exc_code_o),
        .exc_epc_o         (exc_epc_o),
        .exc_bd_o          (exc_bd_o),
        .exc_badvaddr_o    (exc_badvaddr_o),
        .exc_badvaddr_we_o (exc_badvaddr_we_o),
        .flush_o           (flush_o),
        .stall_o           (stall_o),
        .redirect_valid_o  (redirect_valid_o),
        .redirect_pc_o     (redirect_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        mem_valid_i     = 1'b0;
        mem_pc_i        = 32'd0;
        mem_delayslot_i = 1'b0;
        exc_if_adel_i   = 1'b0;
        exc_ri_i        = 1'b0;
        exc_ov_i        = 1'b0;
        exc_sys_i       = 1'b0;
        exc_bp_i        = 1'b0;
        exc_adel_i      = 1'b0;
        exc_ades_i      = 1'b0;
        eret_i          = 1'b0;
        mem_addr_i      = 32'd0;
        hw_int_i        = 6'd0;
    endtask

    initial begin
        rst      = 1'b1;
        status_i = 32'd0;
        cause_i  = 32'd0;
        epc_i    = 32'd0;
        clear_req();
        tick();
        tick();
        // reset state
        chk("rst_commit",   {31'd0, exc_commit_o},     32'd0);
        chk("rst_eret",     {31'd0, eret_commit_o},    32'd0);
        chk("rst_flush",    {31'd0, flush_o},          32'd0);
        chk("rst_stall",    {31'd0, stall_o},          32'd0);
        chk("rst_redir",    {31'd0, redirect_valid_o}, 32'd0);
        chk("rst_redir_pc", redirect_pc_o,             32'd0);
        chk("rst_code",     {27'd0, exc_code_o},       32'd0);
        chk("rst_epc",      exc_epc_o,                 32'd0);
        chk("rst_bv",       exc_badvaddr_o,            32'd0);
        rst = 1'b0;
        tick();

        // syscall, no delay slot
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'hBFC0_0100;
        exc_sys_i   = 1'b1;
        tick();
        chk("sys_commit", {31'd0, exc_commit_o},      32'd1);
        chk("sys_code",   {27'd0, exc_code_o},        32'd8);
        chk("sys_epc",    exc_epc_o,                  32'hBFC0_0100);
        chk("sys_bd",     {31'd0, exc_bd_o},          32'd0);
        chk("sys_bvwe",   {31'd0, exc_badvaddr_we_o}, 32'd0);
        chk("sys_flush1", {31'd0, flush_o},           32'd1);
        chk("sys_stall1", {31'd0, stall_o},           32'd1);
        chk("sys_eretc",  {31'd0, eret_commit_o},     32'd0);
        clear_req();
        tick();
        chk("sys_commit2", {31'd0, exc_commit_o},     32'd0);
        chk("sys_flush2",  {31'd0, flush_o},          32'd1);
        chk("sys_redir_early", {31'd0, redirect_valid_o}, 32'd0);
        tick();
        chk("sys_redir",    {31'd0, redirect_valid_o}, 32'd1);
        chk("sys_redir_pc", redirect_pc_o,             32'hBFC0_0380);
        chk("sys_flush3",   {31'd0, flush_o},          32'd0);
        chk("sys_stall3",   {31'd0, stall_o},          32'd0);
        tick();
        chk("sys_idle_redir", {31'd0, redirect_valid_o}, 32'd0);

        // load AdEL in a delay slot
        mem_valid_i     = 1'b1;
        mem_pc_i        = 32'h8000_0020;
        mem_delayslot_i = 1'b1;
        mem_addr_i      = 32'h0000_0003;
        exc_adel_i      = 1'b1;
        tick();
        chk("adel_commit", {31'd0, exc_commit_o},      32'd1);
        chk("adel_code",   {27'd0, exc_code_o},        32'd4);
        chk("adel_epc",    exc_epc_o,                  32'h8000_001C);
        chk("adel_bd",     {31'd0, exc_bd_o},          32'd1);
        chk("adel_bv",     exc_badvaddr_o,             32'h0000_0003);
        chk("adel_bvwe",   {31'd0, exc_badvaddr_we_o}, 32'd1);
        clear_req();
        tick();
        chk("adel_bvwe2", {31'd0, exc_badvaddr_we_o}, 32'd0);
        tick();
        tick();

        // fetch AdEL outranks store AdES; BadVAddr comes from the PC
        mem_valid_i   = 1'b1;
        mem_pc_i      = 32'h8000_0041;
        mem_addr_i    = 32'h1234_5679;
        exc_if_adel_i = 1'b1;
        exc_ades_i    = 1'b1;
        tick();
        chk("ifadel_code", {27'd0, exc_code_o}, 32'd4);
        chk("ifadel_bv",   exc_badvaddr_o,      32'h8000_0041);
        chk("ifadel_bd",   {31'd0, exc_bd_o},   32'd0);
        clear_req();
        tick();
        tick();
        tick();

        // interrupt held pending until a valid instruction reaches MEM
        status_i = 32'h0000_0401;
        hw_int_i = 6'b000001;
        tick();
        tick();
        chk("int_wait_flush", {31'd0, flush_o}, 32'd0);
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0100;
        tick();
        chk("int_commit", {31'd0, exc_commit_o}, 32'd1);
        chk("int_code",   {27'd0, exc_code_o},   32'd0);
        chk("int_epc",    exc_epc_o,             32'h8000_0100);
        clear_req();
        tick();
        tick();
        tick();

        // EXL set masks the interrupt
        status_i    = 32'h0000_0403;
        hw_int_i    = 6'b000001;
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0200;
        tick();
        chk("exl_commit", {31'd0, exc_commit_o}, 32'd0);
        tick();
        chk("exl_flush",  {31'd0, flush_o},      32'd0);
        clear_req();
        status_i = 32'd0;

        // ERET
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0300;
        eret_i      = 1'b1;
        epc_i       = 32'h8000_1000;
        tick();
        chk("eret_pulse",    {31'd0, eret_commit_o}, 32'd1);
        chk("eret_nocommit", {31'd0, exc_commit_o},  32'd0);
        chk("eret_flush",    {31'd0, flush_o},       32'd1);
        chk("eret_epc_hold", exc_epc_o,              32'h8000_0100);
        clear_req();
        epc_i = 32'd0;
        tick();
        chk("eret_pulse2", {31'd0, eret_commit_o}, 32'd0);
        tick();
        chk("eret_redir",    {31'd0, redirect_valid_o}, 32'd1);
        chk("eret_redir_pc", redirect_pc_o,             32'h8000_1000);
        tick();

        // RI+Ov+Bp with ERET: RI wins, ERET dropped; syscall during FLUSH ignored
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0400;
        exc_ri_i    = 1'b1;
        exc_ov_i    = 1'b1;
        exc_bp_i    = 1'b1;
        eret_i      = 1'b1;
        epc_i       = 32'h8000_2000;
        tick();
        chk("multi_code",   {27'd0, exc_code_o},    32'd10);
        chk("multi_commit", {31'd0, exc_commit_o},  32'd1);
        chk("multi_eretc",  {31'd0, eret_commit_o}, 32'd0);
        clear_req();
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0500;
        exc_sys_i   = 1'b1;
        tick();
        chk("ign_commit", {31'd0, exc_commit_o}, 32'd0);
        chk("ign_code",   {27'd0, exc_code_o},   32'd10);
        chk("ign_epc",    exc_epc_o,             32'h8000_0400);
        tick();
        chk("multi_redir_pc", redirect_pc_o, 32'hBFC0_0380);
        clear_req();
        tick();
        chk("multi_idle_flush", {31'd0, flush_o}, 32'd0);

        // reset in the middle of FLUSH
        mem_valid_i = 1'b1;
        mem_pc_i    = 32'h8000_0600;
        exc_sys_i   = 1'b1;
        tick();
        chk("mrst_commit", {31'd0, exc_commit_o}, 32'd1);
        clear_req();
        rst = 1'b1;
        tick();
        chk("mrst_flush", {31'd0, flush_o},          32'd0);
        chk("mrst_stall", {31'd0, stall_o},          32'd0);
        chk("mrst_code",  {27'd0, exc_code_o},       32'd0);
        chk("mrst_epc",   exc_epc_o,                 32'd0);
        chk("mrst_redir", {31'd0, redirect_valid_o}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mrst_redir2", {31'd0, redirect_valid_o}, 32'd0);
        tick();
        chk("mrst_redir3", {31'd0, redirect_valid_o}, 32'd0);
        chk("mrst_flush3", {31'd0, flush_o},          32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
